de2i150_input_conditioner: RTL and testbench

Upstream conditioning stage for the DE2i-150 board I/O path. It synchronises and debounces the 18 slide switches and the 4 active-low push-buttons, and emits one-cycle press pulses. Its debounced outputs drive the LED/IO test logic directly, replacing raw pin wiring. The LED stage keeps its existing polarity conventions: KEY_DB stays active-low.

---
 rtl/de2i150_input_conditioner.sv | 94 +++++++++
 tb/tb_de2i150_input_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/de2i150_input_conditioner.sv
// de2i150_input_conditioner: two-flop synchroniser and per-bit debounce for SW/KEY, plus key press pulses.
// Optional press counter is compiled when `define INPUT_COND_PRESS_COUNT_EN is set.
module de2i150_input_conditioner #(
   parameter int SW_W            = 18,
   parameter int KEY_W           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic              CLOCK_50,
   input  logic              RST_N,
   input  logic [SW_W-1:0]   SW,
   input  logic [KEY_W-1:0]  KEY,
   output logic [SW_W-1:0]   SW_DB,
   output logic [KEY_W-1:0]  KEY_DB,
   output logic [KEY_W-1:0]  KEY_PRESS,
   output logic [7:0]        PRESS_COUNT
);

   localparam int N = SW_W + KEY_W;
   // Switches idle low, buttons idle high (active-low)
   localparam logic [N-1:0]     RST_VAL  = {{KEY_W{1'b1}}, {SW_W{1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [N-1:0]            sync1;
   logic [N-1:0]            sync2;
   logic [N-1:0]            db;
   logic [N-1:0]            db_nxt;
   logic [N-1:0][CNT_W-1:0] cnt;
   logic [N-1:0][CNT_W-1:0] cnt_nxt;
   logic [KEY_W-1:0]        key_press;

   always_comb begin
      db_nxt  = db;
      cnt_nxt = '0;
      for (int i = 0; i < N; i++) begin
         if (sync2[i] != db[i]) begin
            if (cnt[i] == CNT_LAST) begin
               db_nxt[i] = sync2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_ONE;
            end
         end
      end
   end

   // Stage boundary: sync1 -> sync2 -> debounced state; press is the registered falling edge of KEY_DB
   always_ff @(posedge CLOCK_50) begin
      if (!RST_N) begin
         sync1     <= RST_VAL;
         sync2     <= RST_VAL;
         db        <= RST_VAL;
         cnt       <= '0;
         key_press <= '0;
      end else begin
         sync1     <= {KEY, SW};
         sync2     <= sync1;
         db        <= db_nxt;
         cnt       <= cnt_nxt;
         key_press <= db[N-1:SW_W] & ~db_nxt[N-1:SW_W];
      end
   end

   assign SW_DB     = db[SW_W-1:0];
   assign KEY_DB    = db[N-1:SW_W];
   assign KEY_PRESS = key_press;

`ifdef INPUT_COND_PRESS_COUNT_EN
   function automatic logic [7:0] popcount(input logic [KEY_W-1:0] v);
      logic [7:0] s;
      s = '0;
      for (int i = 0; i < KEY_W; i++) begin
         s = s + 8'(v[i]);
      end
      return s;
   endfunction

   logic [7:0] press_cnt;

   // Counter lags KEY_PRESS by one cycle and wraps modulo 256
   always_ff @(posedge CLOCK_50) begin
      if (!RST_N) begin
         press_cnt <= '0;
      end else begin
         press_cnt <= press_cnt + popcount(key_press);
      end
   end

   assign PRESS_COUNT = press_cnt;
`else
   assign PRESS_COUNT = 8'd0;
`endif

endmodule

// File: tb/tb_de2i150_input_conditioner.sv
// Bench for de2i150_input_conditioner: sliding-window reference model checked every cycle, plus directed literal checks.
module tb_de2i150_input_conditioner;

   localparam int SW_W  = 18;
   localparam int KEY_W = 4;
   localparam int D     = 8;
   localparam int N     = SW_W + KEY_W;
`ifdef INPUT_COND_PRESS_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif
   localparam logic [N-1:0] RSTV = {4'hF, 18'h0};

   logic              clk = 1'b0;
   logic              rst_n;
   logic [SW_W-1:0]   sw;
   logic [KEY_W-1:0]  key;
   logic [SW_W-1:0]   sw_db;
   logic [KEY_W-1:0]  key_db;
   logic [KEY_W-1:0]  key_press;
   logic [7:0]        press_count;

   int n_chk  = 0;
   int n_fail = 0;
   int pulses = 0;
   bit mon_en = 1'b0;

   de2i150_input_conditioner #(
      .SW_W(SW_W), .KEY_W(KEY_W), .DEBOUNCE_CYCLES(D), .CNT_W(4)
   ) dut (
      .CLOCK_50(clk), .RST_N(rst_n), .SW(sw), .KEY(key),
      .SW_DB(sw_db), .KEY_DB(key_db), .KEY_PRESS(key_press), .PRESS_COUNT(press_count)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pc(input logic [KEY_W-1:0] v);
      logic [7:0] s;
      s = '0;
      for (int i = 0; i < KEY_W; i++) s = s + 8'(v[i]);
      return s;
   endfunction

   // Reference: an output bit flips only when the last D synchronised samples all disagree with it
   logic [N-1:0]     h [0:D+1];
   logic [N-1:0]     m_db;
   logic [KEY_W-1:0] m_press;
   logic [7:0]       m_cnt;

   always @(posedge clk) begin
      logic [N-1:0] nd;
      bit all_diff;
      if (!rst_n) begin
         for (int k = 0; k <= D + 1; k++) h[k] = RSTV;
         m_db    = RSTV;
         m_press = '0;
         m_cnt   = '0;
         mon_en  = 1'b1;
      end else begin
         if (CNT_EN) m_cnt = m_cnt + pc(m_press);
         for (int k = D + 1; k > 0; k--) h[k] = h[k-1];
         h[0] = {key, sw};
         nd = m_db;
         for (int b = 0; b < N; b++) begin
            all_diff = 1'b1;
            for (int k = 2; k <= D + 1; k++) if (h[k][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) nd[b] = ~m_db[b];
         end
         m_press = m_db[N-1:SW_W] & ~nd[N-1:SW_W];
         m_db    = nd;
      end
      #1;
      if (mon_en) begin
         chk("model_sw_db",   32'(sw_db),       32'(m_db[SW_W-1:0]));
         chk("model_key_db",  32'(key_db),      32'(m_db[N-1:SW_W]));
         chk("model_press",   32'(key_press),   32'(m_press));
         chk("model_count",   32'(press_count), 32'(m_cnt));
      end
   end

   task automatic step_count(input int n, input int idx);
      repeat (n) begin
         @(negedge clk);
         if (key_press[idx]) pulses++;
      end
   endtask

   task automatic do_reset();
      sw    = '0;
      key   = 4'hF;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      sw    = 18'h3FFFF;
      key   = 4'h0;
      repeat (3) @(negedge clk);
      chk("rst_sw_db",  32'(sw_db),       32'h0);
      chk("rst_key_db", 32'(key_db),      32'hF);
      chk("rst_press",  32'(key_press),   32'h0);
      chk("rst_count",  32'(press_count), 32'h0);
      rst_n = 1'b1;
      repeat (9) @(negedge clk);
      chk("rel_sw_db_early",  32'(sw_db),  32'h0);
      chk("rel_key_db_early", 32'(key_db), 32'hF);
      @(negedge clk);
      chk("rel_sw_db",  32'(sw_db),     32'h3FFFF);
      chk("rel_key_db", 32'(key_db),    32'h0);
      chk("rel_press",  32'(key_press), 32'hF);
      @(negedge clk);
      chk("rel_press_off", 32'(key_press),   32'h0);
      chk("rel_count",     32'(press_count), CNT_EN ? 32'd4 : 32'd0);

      // Glitch rejection on SW[5]
      do_reset();
      sw[5] = 1'b1;
      repeat (7) @(negedge clk);
      sw[5] = 1'b0;
      repeat (12) @(negedge clk);
      chk("glitch7_sw5", 32'(sw_db[5]), 32'h0);
      sw[5] = 1'b1;
      repeat (8) @(negedge clk);
      sw[5] = 1'b0;
      @(negedge clk);
      chk("hold8_sw5_edge9", 32'(sw_db[5]), 32'h0);
      @(negedge clk);
      chk("hold8_sw5_edge10", 32'(sw_db[5]), 32'h1);
      repeat (12) @(negedge clk);
      chk("hold8_sw5_back", 32'(sw_db[5]), 32'h0);

      // Bouncing KEY[2]
      do_reset();
      pulses = 0;
      key[2] = 1'b0; step_count(3, 2);
      key[2] = 1'b1; step_count(3, 2);
      key[2] = 1'b0; step_count(9, 2);
      chk("bounce_db_early", 32'(key_db[2]), 32'h1);
      step_count(1, 2);
      chk("bounce_db_fall", 32'(key_db[2]),    32'h0);
      chk("bounce_press",   32'(key_press[2]), 32'h1);
      step_count(5, 2);
      chk("bounce_pulses", 32'(pulses),      32'd1);
      chk("bounce_count",  32'(press_count), CNT_EN ? 32'd1 : 32'd0);

      // Release of KEY[2]
      pulses = 0;
      key[2] = 1'b1; step_count(9, 2);
      chk("release_db_early", 32'(key_db[2]), 32'h0);
      step_count(1, 2);
      chk("release_db_rise", 32'(key_db[2]), 32'h1);
      step_count(5, 2);
      chk("release_pulses", 32'(pulses),      32'd0);
      chk("release_count",  32'(press_count), CNT_EN ? 32'd1 : 32'd0);

      // Preload 254 presses, then three simultaneous presses wrap the counter
      do_reset();
      for (int i = 0; i < 254; i++) begin
         key[0] = 1'b0;
         repeat (11) @(negedge clk);
         key[0] = 1'b1;
         repeat (11) @(negedge clk);
      end
      chk("preload_count", 32'(press_count), CNT_EN ? 32'd254 : 32'd0);
      key = 4'b0100;
      repeat (9) @(negedge clk);
      chk("multi_press_early", 32'(key_press), 32'h0);
      @(negedge clk);
      chk("multi_press", 32'(key_press), 32'hB);
      @(negedge clk);
      chk("multi_press_off", 32'(key_press),   32'h0);
      chk("wrap_count",      32'(press_count), CNT_EN ? 32'd1 : 32'd0);
      key = 4'hF;
      repeat (12) @(negedge clk);

      // Reset in the middle of a KEY[1] debounce
      do_reset();
      pulses = 0;
      key[1] = 1'b0;
      step_count(5, 1);
      rst_n = 1'b0;
      step_count(1, 1);
      rst_n = 1'b1;
      step_count(9, 1);
      chk("midrst_db_early", 32'(key_db[1]), 32'h1);
      chk("midrst_no_pulse", 32'(pulses),    32'd0);
      step_count(1, 1);
      chk("midrst_db_fall", 32'(key_db[1]),    32'h0);
      chk("midrst_press",   32'(key_press[1]), 32'h1);
      step_count(3, 1);
      chk("midrst_pulses", 32'(pulses),      32'd1);
      chk("midrst_count",  32'(press_count), CNT_EN ? 32'd1 : 32'd0);

      key = 4'hF;
      repeat (4) @(negedge clk);
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
